// File: rtl/siso_pkg.sv
// Shared types, constants and trellis tables for the 8-state max-log-MAP SISO
// decoder; used by both the forward (alpha) and backward (beta) recursions.
package siso_pkg;

  localparam int NUM_STATES = 8;
  localparam int METRIC_W   = 19;
  localparam int OUT_W      = 16;
  localparam int INIT_NEG   = -128;

  typedef logic signed [METRIC_W-1:0] metric_t;
  typedef logic signed [OUT_W-1:0]    out_metric_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_PREF  = 2'd2,
    ST_DRAIN = 2'd3
  } beta_fsm_e;

  // State s combines successors s/2 and s/2+4; bit s picks gamma2 over gamma1
  // and whether the first branch adds (the second branch uses the opposite sign).
  localparam logic [NUM_STATES-1:0] TRELLIS_GSEL = 8'b0011_1100;
  localparam logic [NUM_STATES-1:0] TRELLIS_POS  = 8'b1001_1001;

  function automatic int unsigned trellis_succ(input int unsigned s, input logic upper);
    return (s >> 1) + (upper ? (NUM_STATES / 2) : 0);
  endfunction

  function automatic metric_t init_metric(input int s);
    return (s == 0) ? '0 : metric_t'(INIT_NEG);
  endfunction

  function automatic out_metric_t sat_metric(input metric_t v);
    if (v > metric_t'(32767)) return 16'sh7FFF;
    if (v < metric_t'(-32768)) return 16'sh8000;
    return out_metric_t'(v);
  endfunction

endpackage

// File: rtl/gamma_lifo.sv
// Simple dual-port branch-metric store: written in forward order, read back in
// reverse by the caller's addressing. Synchronous read, one-cycle latency.
module gamma_lifo #(
  parameter int DEPTH = 6144,
  parameter int AW    = 13,
  parameter int W     = 32
) (
  input  logic          clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_wr_addr,
  input  logic [W-1:0]  i_wr_data,
  input  logic          i_rd_en,
  input  logic [AW-1:0] i_rd_addr,
  output logic [W-1:0]  o_rd_data
);

  logic [W-1:0] r_mem [DEPTH];

  // Read data holds when i_rd_en is low, so a stalled consumer keeps its gamma.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
    if (i_rd_en) o_rd_data <= r_mem[i_rd_addr];
  end

endmodule

// File: rtl/beta_recursion.sv
// Backward state-metric unit: buffers one frame of gamma pairs, then runs the
// beta recursion from k=K-1 down to 0 and streams normalized vectors out.
module beta_recursion
  import siso_pkg::*;
#(
  parameter int MAX_K = 6144
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic signed [15:0] gamma1,
  input  logic signed [15:0] gamma2,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [15:0] beta_0,
  output logic signed [15:0] beta_1,
  output logic signed [15:0] beta_2,
  output logic signed [15:0] beta_3,
  output logic signed [15:0] beta_4,
  output logic signed [15:0] beta_5,
  output logic signed [15:0] beta_6,
  output logic signed [15:0] beta_7,
  output logic [12:0]        beta_idx,
  output logic               beta_last,
  output logic               frame_overflow,
  output beta_fsm_e          dbg_state
);

  localparam int AW = (MAX_K > 1) ? $clog2(MAX_K) : 1;

  beta_fsm_e     r_state, w_state_nxt;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr, w_rd_addr;
  logic          r_overflow;
  metric_t       r_beta     [NUM_STATES];
  metric_t       w_gv       [NUM_STATES];
  metric_t       w_op1      [NUM_STATES];
  metric_t       w_op2      [NUM_STATES];
  metric_t       w_acs      [NUM_STATES];
  metric_t       w_beta_nxt [NUM_STATES];
  logic [31:0]   w_rd_data;
  metric_t       w_g1, w_g2;
  logic          w_accept, w_ptr_full, w_frame_end, w_out_acc, w_final, w_rd_en;

  // Handshakes: a beat transfers on a rising edge where valid && ready; the
  // sender holds valid and data until then, and out_valid never drops early.
  assign in_ready    = (r_state == ST_IDLE) || (r_state == ST_FILL);
  assign w_accept    = in_valid && in_ready;
  assign w_ptr_full  = (r_wr_ptr == AW'(MAX_K - 1));
  assign w_frame_end = w_accept && (in_last || w_ptr_full);
  assign out_valid   = (r_state == ST_DRAIN);
  assign w_out_acc   = out_valid && out_ready;
  assign w_final     = w_out_acc && (r_rd_ptr == '0);
  assign w_rd_en     = (r_state == ST_PREF) || (w_out_acc && !w_final);
  assign w_rd_addr   = (r_state == ST_PREF) ? r_rd_ptr : r_rd_ptr - AW'(1);

  gamma_lifo #(.DEPTH(MAX_K), .AW(AW), .W(32)) u_lifo (
    .clk       (clk),
    .i_wr_en   (w_accept),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data ({gamma1, gamma2}),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (w_rd_addr),
    .o_rd_data (w_rd_data)
  );

  assign w_g1 = metric_t'($signed(w_rd_data[31:16]));
  assign w_g2 = metric_t'($signed(w_rd_data[15:0]));

  // Add-compare-select; ties keep the first operand, then subtract state 0.
  always_comb begin
    for (int s = 0; s < NUM_STATES; s++) begin
      w_gv[s]  = TRELLIS_GSEL[s] ? w_g2 : w_g1;
      w_op1[s] = TRELLIS_POS[s] ? r_beta[trellis_succ(s, 1'b0)] + w_gv[s]
                                : r_beta[trellis_succ(s, 1'b0)] - w_gv[s];
      w_op2[s] = TRELLIS_POS[s] ? r_beta[trellis_succ(s, 1'b1)] - w_gv[s]
                                : r_beta[trellis_succ(s, 1'b1)] + w_gv[s];
      w_acs[s] = (w_op1[s] >= w_op2[s]) ? w_op1[s] : w_op2[s];
    end
    for (int s = 0; s < NUM_STATES; s++) begin
      w_beta_nxt[s] = w_acs[s] - w_acs[0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = w_frame_end ? ST_PREF : ST_FILL;
      ST_FILL:  if (w_frame_end) w_state_nxt = ST_PREF;
      ST_PREF:  w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_final) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
      for (int s = 0; s < NUM_STATES; s++) r_beta[s] <= init_metric(s);
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) r_wr_ptr <= w_frame_end ? '0 : r_wr_ptr + AW'(1);
      if (w_frame_end) r_rd_ptr <= r_wr_ptr;
      // A full LIFO closes the frame even without in_last; flag stays until reset.
      if (w_accept && w_ptr_full && !in_last) r_overflow <= 1'b1;
      if (r_state == ST_PREF) begin
        for (int s = 0; s < NUM_STATES; s++) r_beta[s] <= init_metric(s);
      end else if (w_out_acc && !w_final) begin
        for (int s = 0; s < NUM_STATES; s++) r_beta[s] <= w_beta_nxt[s];
        r_rd_ptr <= r_rd_ptr - AW'(1);
      end
    end
  end

  assign beta_0         = sat_metric(r_beta[0]);
  assign beta_1         = sat_metric(r_beta[1]);
  assign beta_2         = sat_metric(r_beta[2]);
  assign beta_3         = sat_metric(r_beta[3]);
  assign beta_4         = sat_metric(r_beta[4]);
  assign beta_5         = sat_metric(r_beta[5]);
  assign beta_6         = sat_metric(r_beta[6]);
  assign beta_7         = sat_metric(r_beta[7]);
  assign beta_idx       = 13'(r_rd_ptr);
  assign beta_last      = out_valid && (r_rd_ptr == '0);
  assign frame_overflow = r_overflow;
  assign dbg_state      = r_state;

endmodule

// File: tb/tb_beta_recursion.sv
// Directed bench for beta_recursion with a small LIFO (MAX_K=8): hand-computed
// vectors for tiny frames, an independent recursion model for longer ones.
module tb_beta_recursion;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst, in_valid, in_ready, in_last;
  logic               out_valid, out_ready, beta_last, frame_overflow;
  logic signed [15:0] gamma1, gamma2;
  logic signed [15:0] beta_0, beta_1, beta_2, beta_3, beta_4, beta_5, beta_6, beta_7;
  logic [12:0]        beta_idx;
  logic [1:0]         dbg_state;
  logic [127:0]       w_vec;

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] exp_q[$];
  logic [12:0]  exp_idx_q[$];
  int           stim_g1[16];
  int           stim_g2[16];

  assign w_vec = {beta_7, beta_6, beta_5, beta_4, beta_3, beta_2, beta_1, beta_0};

  beta_recursion #(.MAX_K(8)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_last        (in_last),
    .gamma1         (gamma1),
    .gamma2         (gamma2),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .beta_0         (beta_0),
    .beta_1         (beta_1),
    .beta_2         (beta_2),
    .beta_3         (beta_3),
    .beta_4         (beta_4),
    .beta_5         (beta_5),
    .beta_6         (beta_6),
    .beta_7         (beta_7),
    .beta_idx       (beta_idx),
    .beta_last      (beta_last),
    .frame_overflow (frame_overflow),
    .dbg_state      (dbg_state)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] pack8(input int v0, input int v1, input int v2, input int v3,
                                         input int v4, input int v5, input int v6, input int v7);
    return {16'(v7), 16'(v6), 16'(v5), 16'(v4), 16'(v3), 16'(v2), 16'(v1), 16'(v0)};
  endfunction

  function automatic int max2(input int a, input int b);
    return (a >= b) ? a : b;
  endfunction

  // Reference recursion written straight from the trellis equations.
  task automatic model_frame(input int n);
    int b[8];
    int nb[8];
    int g1, g2;
    b[0] = 0;
    for (int i = 1; i < 8; i++) b[i] = -128;
    for (int k = n - 1; k >= 0; k--) begin
      exp_q.push_back(pack8(b[0], b[1], b[2], b[3], b[4], b[5], b[6], b[7]));
      exp_idx_q.push_back(13'(k));
      g1 = stim_g1[k];
      g2 = stim_g2[k];
      nb[0] = max2(b[0] + g1, b[4] - g1);
      nb[1] = max2(b[0] - g1, b[4] + g1);
      nb[2] = max2(b[1] - g2, b[5] + g2);
      nb[3] = max2(b[1] + g2, b[5] - g2);
      nb[4] = max2(b[2] + g2, b[6] - g2);
      nb[5] = max2(b[2] - g2, b[6] + g2);
      nb[6] = max2(b[3] - g1, b[7] + g1);
      nb[7] = max2(b[3] + g1, b[7] - g1);
      for (int i = 0; i < 8; i++) b[i] = nb[i] - nb[0];
    end
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send_beat(input int g1, input int g2, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    gamma1   = 16'(g1);
    gamma2   = 16'(g2);
    in_last  = last;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("send_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input int n, input logic with_last);
    for (int k = 0; k < n; k++) send_beat(stim_g1[k], stim_g2[k], with_last && (k == n - 1));
  endtask

  // Collects n vectors against the expected queues; optionally stalls 3 cycles at stall_idx.
  task automatic collect(input string tag, input int n, input int stall_idx);
    int           got, cyc;
    logic         stalled;
    logic [127:0] held_v, ev;
    logic [12:0]  held_i, ei;
    got = 0;
    cyc = 0;
    stalled = 1'b0;
    out_ready = 1'b1;
    while (got < n && cyc < 300) begin
      if (out_valid && stall_idx >= 0 && int'(beta_idx) == stall_idx && !stalled) begin
        stalled   = 1'b1;
        out_ready = 1'b0;
        held_v    = w_vec;
        held_i    = beta_idx;
        repeat (3) begin
          @(negedge clk);
          cyc++;
          check({tag, "_stall_beta"}, w_vec, held_v);
          check({tag, "_stall_idx"}, beta_idx, held_i);
          check({tag, "_stall_valid"}, out_valid, 1);
        end
        out_ready = 1'b1;
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check({tag, "_extra_vector"}, 1, 0);
        end else begin
          ev = exp_q.pop_front();
          ei = exp_idx_q.pop_front();
          check({tag, "_beta"}, w_vec, ev);
          check({tag, "_idx"}, beta_idx, ei);
          check({tag, "_last"}, beta_last, (ei == 13'd0));
          check({tag, "_in_ready_drain"}, in_ready, 0);
        end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    if (got < n) check({tag, "_collect_timeout"}, got, n);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; gamma1 = '0; gamma2 = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_beta_last", beta_last, 0);
    check("rst_beta_idx", beta_idx, 0);
    check("rst_overflow", frame_overflow, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_beta_vec", w_vec, pack8(0, -128, -128, -128, -128, -128, -128, -128));

    // K=1: single beat with last, vector appears two cycles after acceptance
    stim_g1[0] = 10; stim_g2[0] = 0;
    send_frame(1, 1'b1);
    check("k1_pref_valid", out_valid, 0);
    check("k1_pref_ready", in_ready, 0);
    check("k1_pref_state", dbg_state, 2);
    @(negedge clk);
    check("k1_latency_valid", out_valid, 1);
    exp_q.push_back(pack8(0, -128, -128, -128, -128, -128, -128, -128));
    exp_idx_q.push_back(13'd0);
    collect("k1", 1, -1);
    check("k1_idle_ready", in_ready, 1);
    check("k1_idle_valid", out_valid, 0);
    check("k1_overflow", frame_overflow, 0);

    // K=2 with hand-derived expected vectors
    stim_g1[0] = 10; stim_g2[0] = 5;
    stim_g1[1] = 20; stim_g2[1] = -3;
    send_frame(2, 1'b1);
    exp_q.push_back(pack8(0, -128, -128, -128, -128, -128, -128, -128));
    exp_idx_q.push_back(13'd1);
    exp_q.push_back(pack8(0, -40, -145, -145, -145, -145, -128, -128));
    exp_idx_q.push_back(13'd0);
    collect("k2", 2, -1);
    check("k2_done_valid", out_valid, 0);

    // K=6 with a 3-cycle stall at idx 3
    stim_g1[0] = 3;   stim_g2[0] = -4;
    stim_g1[1] = -7;  stim_g2[1] = 6;
    stim_g1[2] = 12;  stim_g2[2] = 1;
    stim_g1[3] = 0;   stim_g2[3] = -15;
    stim_g1[4] = -25; stim_g2[4] = 8;
    stim_g1[5] = 9;   stim_g2[5] = 2;
    model_frame(6);
    send_frame(6, 1'b1);
    collect("bp", 6, 3);
    check("bp_queue_empty", exp_q.size(), 0);
    check("bp_done_valid", out_valid, 0);

    // Overflow: 8 beats without last fill the LIFO; 9th beat waits for IDLE
    for (int k = 0; k < 8; k++) begin
      stim_g1[k] = 5 * k - 11;
      stim_g2[k] = 7 - 3 * k;
    end
    model_frame(8);
    send_frame(8, 1'b0);
    check("ovf_flag", frame_overflow, 1);
    check("ovf_pref_ready", in_ready, 0);
    in_valid = 1'b1; gamma1 = 16'sd99; gamma2 = -16'sd1; in_last = 1'b0;
    collect("ovf", 8, -1);
    check("ovf_queue_empty", exp_q.size(), 0);
    check("ovf_idle_ready", in_ready, 1);
    check("ovf_sticky", frame_overflow, 1);
    stim_g1[0] = 99; stim_g2[0] = -1;
    stim_g1[1] = 5;  stim_g2[1] = 6;
    model_frame(2);
    send_frame(2, 1'b1);
    collect("ovf_next", 2, -1);

    // Reset while draining at idx 3, then decode a fresh frame
    stim_g1[0] = 14; stim_g2[0] = -2;
    stim_g1[1] = -3; stim_g2[1] = 9;
    stim_g1[2] = 6;  stim_g2[2] = 6;
    stim_g1[3] = -8; stim_g2[3] = -5;
    stim_g1[4] = 1;  stim_g2[4] = 13;
    stim_g1[5] = 20; stim_g2[5] = -7;
    model_frame(6);
    send_frame(6, 1'b1);
    collect("prerst", 2, -1);
    check("prerst_idx3", beta_idx, 3);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_overflow", frame_overflow, 0);
    check("midrst_idx", beta_idx, 0);
    rst = 1'b0;
    exp_q.delete();
    exp_idx_q.delete();
    stim_g1[0] = -4; stim_g2[0] = 11;
    stim_g1[1] = 17; stim_g2[1] = 3;
    stim_g1[2] = 2;  stim_g2[2] = -9;
    model_frame(3);
    send_frame(3, 1'b1);
    collect("postrst", 3, -1);

    // Back-to-back: in_valid stays high through PREF/DRAIN of frame A
    stim_g1[0] = 8;   stim_g2[0] = 1;
    stim_g1[1] = -12; stim_g2[1] = 4;
    stim_g1[2] = 5;   stim_g2[2] = -6;
    model_frame(3);
    send_frame(3, 1'b1);
    in_valid = 1'b1; gamma1 = 16'sd4; gamma2 = -16'sd9; in_last = 1'b0;
    check("b2b_pref_ready", in_ready, 0);
    collect("b2b_a", 3, -1);
    check("b2b_restart_ready", in_ready, 1);
    stim_g1[0] = 4;  stim_g2[0] = -9;
    stim_g1[1] = -6; stim_g2[1] = 11;
    stim_g1[2] = 2;  stim_g2[2] = 2;
    send_beat(stim_g1[0], stim_g2[0], 1'b0);
    check("b2b_first_beat_fill", dbg_state, 1);
    send_beat(stim_g1[1], stim_g2[1], 1'b0);
    send_beat(stim_g1[2], stim_g2[2], 1'b1);
    model_frame(3);
    collect("b2b_b", 3, -1);
    check("b2b_queue_empty", exp_q.size(), 0);
    check("b2b_done_ready", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
